latency_pipe_drain: RTL and testbench
=====================================

// Module: latency_pipe_drain
// PURPOSE
//  Receiving end of a fixed, non-stallable latency pipe in the CGRA subsystem.
//  - Issue side: grants issue slots to the producer by credit, so results never outnumber buffer space.
//  - Return side: captures results leaving the pipe, which cannot be back-pressured.
//  - Output side: re-exposes results on a valid/ready interface, so a stalling consumer never loses data.
// PARAMETERS
//  WIDTH  32  data width of returned results
//  DEPTH  4   result buffer entries = max results in flight + buffered (>=1)
//  CNT_W  derived, $clog2(DEPTH+1); not overridable
// PORTS
//  clk           in   1      clock
//  rst_n         in   1      asynchronous reset, active low
//  clr           in   1      synchronous clear, active high
//  issue_valid   in   1      producer requests to launch one op into the pipe
//  issue_ready   out  1      credit available; issue fires when valid&&ready
//  ret_valid     in   1      result emerging from pipe this cycle (unstallable)
//  ret_data      in   WIDTH  result payload
//  out_valid     out  1      buffered result available
//  out_ready     in   1      consumer accepts; pop when valid&&ready
//  out_data      out  WIDTH  head-of-buffer result
//  inflight      out  CNT_W  ops issued but not yet returned
//  occupancy     out  CNT_W  results held in buffer
//  idle          out  1      inflight==0 && occupancy==0
//  err_overflow  out  1      sticky: ret_valid while buffer full
//  err_underflow out  1      sticky: ret_valid while inflight==0
// BEHAVIOUR
//  Reset (rst_n low, async):
//   - credits=DEPTH, inflight=0, occupancy=0.
//   - Outputs: out_valid=0, out_data=0, issue_ready=1, idle=1, both err flags=0.
//  Credits:
//   - issue_ready = (credits != 0); combinational from registered credits only.
//   - Issue fire: credits-1, inflight+1.
//   - Pop: credits+1.
//   - Issue fire and pop in the same cycle: credits unchanged.
//  Return:
//   - ret_valid: inflight-1; ret_data written at tail; occupancy+1.
//   - Simultaneous issue fire and ret_valid: inflight unchanged.
//  Invariant: credits + inflight + occupancy == DEPTH every cycle, absent error.
//  Output:
//   - Registered FIFO with no bypass: result returned in cycle N gives out_valid=1 in cycle N+1 at the earliest.
//   - out_data is the head entry, held stable while out_valid && !out_ready.
//   - out_data = 0 when empty.
//   - Push and pop in the same cycle on a full buffer: legal, occupancy unchanged.
//   - Push into an empty buffer with out_ready=1: no same-cycle pop.
//  Pointers: wrap modulo DEPTH; DEPTH need not be a power of two.
//  Errors:
//   - ret_valid while occupancy==DEPTH: result dropped; err_overflow set; counters unchanged except inflight-1.
//   - ret_valid while inflight==0: err_underflow set; result still buffered if space exists.
//   - Error flags clear only on rst_n or clr.
//  Clear (clr, priority over all other events that cycle):
//   - Restores the reset state next cycle.
//   - Issue, return and pop in that cycle are discarded.
//   - The owner must clear the upstream pipe in the same cycle.
//  idle: registered-state derived; no combinational path from inputs.
//  Latencies: issue->credit update 1 cycle; pop->issue_ready 1 cycle.
// STRUCTURE
//  - No new shared typedefs; CNT_W is computed locally.
//  - Submodule drain_fifo (WIDTH, DEPTH): storage, rd/wr pointers, occupancy, full/empty.
//  - Credit and inflight counters and error flags live in the top level.
// TESTING
//  1. DEPTH=4, issue_valid held high, out_ready=0 -> exactly 4 fires, then issue_ready=0.
//     Returns 0xA0..0xA3 three cycles later -> occupancy=4.
//  2. From state 1, out_ready=1 -> pops 0xA0,0xA1,0xA2,0xA3 in order on consecutive cycles.
//     issue_ready=1 the cycle after the first pop.
//  3. Steady stream: issue, return and pop each cycle, with pipe latency 2 -> credits constant, no errors.
//     Throughput 1/cycle after fill; idle=1 after drain.
//  4. Force ret_valid with inflight=0 -> err_underflow=1.
//     Force ret_valid on a full buffer -> err_overflow=1; buffer contents unchanged.
//  5. clr asserted mid-stream with inflight=2, occupancy=1, and an issue firing that cycle -> next cycle reset state.
//     Results returned during clr are not buffered.
//  6. rst_n pulsed low asynchronously mid-stream -> outputs reach reset values without a clock edge.

Source files
------------

// File: rtl/latency_pipe_drain_pkg.sv
// Shared constants and helpers for the latency pipe drain block.
package latency_pipe_drain_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 4;

  // Increment a buffer index, wrapping at depth (depth need not be a power of two).
  function automatic int wrap_inc(input int ptr, input int depth);
    return (ptr + 1 >= depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/latency_pipe_drain_fifo.sv
// Result buffer: registered FIFO with no bypass. Head data is shown as zero when empty.
// A push into a full buffer is taken only when a pop frees the head slot in the same cycle.
module drain_fifo
  import latency_pipe_drain_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Storage write; no reset needed since reads of empty slots are masked.
  always_ff @(posedge clk) begin
    if (do_push && !clr) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; clear wins over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= PTR_W'(wrap_inc(32'(wr_ptr), DEPTH));
      end
      if (do_pop) begin
        rd_ptr <= PTR_W'(wrap_inc(32'(rd_ptr), DEPTH));
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/latency_pipe_drain.sv
// Receiving end of a fixed-latency, non-stallable pipe. Issue slots are granted by credit
// so returning results always find buffer space; results are re-offered downstream.
//
// Handshakes: a transfer happens on a rising clk edge when valid && ready are both high.
// issue_ready and out_valid depend only on registered state, never on the partner's
// valid/ready in the same cycle. ret_valid has no ready: the pipe cannot be stalled.
module latency_pipe_drain
  import latency_pipe_drain_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic             ret_valid,
  input  logic [WIDTH-1:0] ret_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] inflight,
  output logic [CNT_W-1:0] occupancy,
  output logic             idle,
  output logic             err_overflow,
  output logic             err_underflow
);

  logic [CNT_W-1:0] credits;
  logic [CNT_W-1:0] credit_next;
  logic [CNT_W-1:0] inflight_next;
  logic [CNT_W:0]   credit_sum;
  logic             fire;
  logic             pop;
  logic             ret_dec;
  logic             full;
  logic             empty;

  assign issue_ready = (credits != '0);
  assign fire        = issue_valid && issue_ready;
  assign out_valid   = !empty;
  assign pop         = out_valid && out_ready;
  assign ret_dec     = ret_valid && (inflight != '0);
  assign idle        = (inflight == '0) && (occupancy == '0);

  drain_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .push      (ret_valid),
    .push_data (ret_data),
    .pop       (out_ready),
    .rd_data   (out_data),
    .count     (occupancy),
    .full      (full),
    .empty     (empty)
  );

  // Next credit and in-flight counts; credits saturate at DEPTH so a stray
  // (underflow) result cannot mint extra issue slots when it is popped.
  always_comb begin
    credit_sum = (CNT_W+1)'(credits) + (CNT_W+1)'(pop) - (CNT_W+1)'(fire);
    if (credit_sum > (CNT_W+1)'(DEPTH)) begin
      credit_next = CNT_W'(DEPTH);
    end else begin
      credit_next = credit_sum[CNT_W-1:0];
    end
    inflight_next = inflight + CNT_W'(fire) - CNT_W'(ret_dec);
  end

  // Credit and in-flight registers; clear restores the reset state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits  <= CNT_W'(DEPTH);
      inflight <= '0;
    end else if (clr) begin
      credits  <= CNT_W'(DEPTH);
      inflight <= '0;
    end else begin
      credits  <= credit_next;
      inflight <= inflight_next;
    end
  end

  // Sticky error flags; overflow only when the full buffer is not freeing a slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else if (clr) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (ret_valid && full && !pop) begin
        err_overflow <= 1'b1;
      end
      if (ret_valid && (inflight == '0)) begin
        err_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_latency_pipe_drain.sv
// Bench for latency_pipe_drain: a queue-based model of the pipe and buffer, a scoreboard
// of expected output data, and a monitor that pops it on every accepted output.
module tb_latency_pipe_drain;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic             clr;
  logic             issue_valid;
  logic             issue_ready;
  logic             ret_valid;
  logic [WIDTH-1:0] ret_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] occupancy;
  logic             idle;
  logic             err_overflow;
  logic             err_underflow;

  latency_pipe_drain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr           (clr),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .ret_valid     (ret_valid),
    .ret_data      (ret_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .inflight      (inflight),
    .occupancy     (occupancy),
    .idle          (idle),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model state ----------------
  typedef struct {
    int               due;
    logic [WIDTH-1:0] data;
  } pipe_ent_t;

  pipe_ent_t        pipe_q[$];
  logic [WIDTH-1:0] mdl_buf[$];
  logic [WIDTH-1:0] exp_q[$];
  int               m_credits;
  int               m_inflight;
  bit               m_ovf;
  bit               m_unf;

  int               cyc;
  int               lat;
  int               n_checks;
  int               n_fail;

  bit               drv_iv;
  bit               drv_ordy;
  bit               drv_clr;
  bit               force_ret;
  logic [WIDTH-1:0] force_data;
  logic [WIDTH-1:0] next_data;
  bit               cur_ret;
  bit               cur_from_pipe;
  logic [WIDTH-1:0] cur_ret_data;
  bit               hit;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_credits  = DEPTH;
    m_inflight = 0;
    m_ovf      = 1'b0;
    m_unf      = 1'b0;
    mdl_buf.delete();
    exp_q.delete();
    pipe_q.delete();
  endtask

  // Apply this cycle's events to the abstract model (called just after the clock edge).
  task automatic model_update();
    pipe_ent_t tmp;
    bit        fire;
    bit        pop;
    bit        space;
    if (cur_from_pipe) tmp = pipe_q.pop_front();
    if (drv_clr) begin
      model_reset();
      return;
    end
    fire  = drv_iv && (m_credits > 0);
    pop   = (mdl_buf.size() > 0) && drv_ordy;
    space = (mdl_buf.size() < DEPTH) || pop;
    if (pop) tmp.data = mdl_buf.pop_front();
    if (cur_ret) begin
      if (m_inflight == 0) m_unf = 1'b1;
      else m_inflight--;
      if (space) begin
        mdl_buf.push_back(cur_ret_data);
        exp_q.push_back(cur_ret_data);
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (fire) begin
      m_inflight++;
      pipe_q.push_back('{cyc + lat, next_data});
    end
    m_credits = m_credits - int'(fire) + int'(pop);
    if (m_credits > DEPTH) m_credits = DEPTH;
  endtask

  task automatic check_state();
    chk("issue_ready", 32'(issue_ready), 32'(m_credits > 0));
    chk("inflight", 32'(inflight), 32'(m_inflight));
    chk("occupancy", 32'(occupancy), 32'(mdl_buf.size()));
    chk("out_valid", 32'(out_valid), 32'(mdl_buf.size() > 0));
    chk("idle", 32'(idle), 32'((m_inflight == 0) && (mdl_buf.size() == 0)));
    chk("out_data_head", out_data, (mdl_buf.size() > 0) ? mdl_buf[0] : '0);
    chk("err_overflow", 32'(err_overflow), 32'(m_ovf));
    chk("err_underflow", 32'(err_underflow), 32'(m_unf));
  endtask

  // ---------------- driver ----------------
  // Drive one cycle of inputs (called #1 after a rising edge), then advance.
  task automatic step();
    cur_from_pipe = (pipe_q.size() > 0) && (pipe_q[0].due == cyc);
    if (force_ret) begin
      cur_ret      = 1'b1;
      cur_ret_data = force_data;
    end else if (cur_from_pipe) begin
      cur_ret      = 1'b1;
      cur_ret_data = pipe_q[0].data;
    end else begin
      cur_ret      = 1'b0;
      cur_ret_data = $urandom;
    end
    issue_valid = drv_iv;
    ret_valid   = cur_ret;
    ret_data    = cur_ret_data;
    out_ready   = drv_ordy;
    clr         = drv_clr;
    @(posedge clk);
    model_update();
    cyc++;
    #1;
    check_state();
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      drv_iv    = ($urandom_range(0, 3) != 0);
      drv_ordy  = ($urandom_range(0, 2) != 0);
      next_data = $urandom;
      step();
    end
  endtask

  task automatic drain(input int n);
    drv_iv   = 1'b0;
    drv_ordy = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"}, out_data, 32'd0);
    chk({tag, "_issue_ready"}, 32'(issue_ready), 32'd1);
    chk({tag, "_idle"}, 32'(idle), 32'd1);
    chk({tag, "_inflight"}, 32'(inflight), 32'd0);
    chk({tag, "_occupancy"}, 32'(occupancy), 32'd0);
    chk({tag, "_err_ovf"}, 32'(err_overflow), 32'd0);
    chk({tag, "_err_unf"}, 32'(err_underflow), 32'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  // Every accepted output must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_data at cycle %0d: got 0x%0h with no result expected", cyc, out_data);
      end else if (out_data !== exp_q[0]) begin
        n_fail++;
        $display("FAIL pop_data at cycle %0d: got 0x%0h expected 0x%0h", cyc, out_data, exp_q[0]);
        exp_q.delete(0);
      end else begin
        exp_q.delete(0);
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; lat = 3;
    drv_iv = 0; drv_ordy = 0; drv_clr = 0; force_ret = 0; force_data = '0; next_data = '0;
    cur_ret = 0; cur_from_pipe = 0; cur_ret_data = '0; hit = 0;
    rst_n = 1'b0; clr = 1'b0; issue_valid = 1'b0; ret_valid = 1'b0; ret_data = '0; out_ready = 1'b0;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: fill with issue held high and consumer stalled; data 0xA0.. in issue order
    lat = 3; drv_iv = 1'b1; drv_ordy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      next_data = 32'hA0 + 32'(DEPTH - m_credits);
      step();
    end
    chk("fill_occupancy", 32'(occupancy), 32'(DEPTH));
    chk("fill_issue_ready", 32'(issue_ready), 32'd0);

    // 2: release the consumer, results leave in order and credits come back
    drv_iv = 1'b0;
    drain(6);
    chk("drain_idle", 32'(idle), 32'd1);

    // 3: steady stream with pipe latency 2
    lat = 2; drv_iv = 1'b1; drv_ordy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      next_data = $urandom;
      step();
      if (i > 8) chk("stream_issue_ready", 32'(issue_ready), 32'd1);
    end
    drain(8);
    chk("stream_idle", 32'(idle), 32'd1);

    // 4a: stray return with nothing in flight
    force_ret = 1'b1; force_data = 32'h55; drv_iv = 1'b0; drv_ordy = 1'b0;
    step();
    force_ret = 1'b0;
    chk("underflow_flag", 32'(err_underflow), 32'd1);
    drain(3);

    // 4b: fill again, then force a return on the full buffer
    lat = 3; drv_iv = 1'b1; drv_ordy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      next_data = 32'hB0 + 32'(i);
      step();
    end
    drv_iv = 1'b0; force_ret = 1'b1; force_data = 32'hDEAD;
    step();
    force_ret = 1'b0;
    chk("overflow_flag", 32'(err_overflow), 32'd1);
    chk("overflow_occupancy", 32'(occupancy), 32'(DEPTH));
    drain(6);
    drv_clr = 1'b1;
    step();
    drv_clr = 1'b0;
    chk("clr_err_ovf", 32'(err_overflow), 32'd0);

    // 5: clear with inflight=2, occupancy=1 and an issue firing that cycle
    lat = 3; hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      drv_iv    = ($urandom_range(0, 3) != 0);
      drv_ordy  = ($urandom_range(0, 1) != 0);
      next_data = $urandom;
      if (!hit && m_inflight == 2 && mdl_buf.size() == 1 && m_credits > 0) begin
        drv_iv  = 1'b1;
        drv_clr = 1'b1;
        hit     = 1'b1;
        step();
        drv_clr = 1'b0;
        check_reset_outputs("clr");
        break;
      end
      step();
    end
    chk("clr_scenario_reached", 32'(hit), 32'd1);
    run_random(40);
    drain(8);

    // 6: asynchronous reset mid-stream, observed between clock edges
    lat = 2;
    run_random(20);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    drv_iv = 0; drv_ordy = 0;
    issue_valid = 1'b0; ret_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_state();

    // mixed random traffic, then full drain
    lat = 3;
    run_random(80);
    drain(10);
    chk("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("final_idle", 32'(idle), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
